// File: rtl/frame_streamer.sv
// Raster-order framebuffer read-out engine: credit-gated reads through a fixed-latency
// port, tags carried alongside, and a first-word-fall-through skid FIFO on the output.
module frame_streamer #(
  parameter int PX_WIDTH   = 160,
  parameter int PX_HEIGHT  = 120,
  parameter int PIX_BITS   = 3,
  parameter int ADDR_BITS  = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [PIX_BITS-1:0]  rd_data,
  output logic [PIX_BITS-1:0]  out_pix,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic                 out_eof,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          frame_count
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam int XW  = $clog2(PX_WIDTH + 1);
  localparam int YW  = $clog2(PX_HEIGHT + 1);
  localparam int EW  = PIX_BITS + 3;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PX_WIDTH * PX_HEIGHT - 1);
  localparam logic [XW-1:0]        LAST_X    = XW'(PX_WIDTH - 1);
  localparam logic [YW-1:0]        LAST_Y    = YW'(PX_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state_r;
  logic [XW-1:0]        x_r;
  logic [YW-1:0]        y_r;
  logic [ADDR_BITS-1:0] addr_r;
  logic                 done_r;
  logic [15:0]          frames_r;
  logic [RD_LAT-1:0]    vld_r;
  logic [2:0]           tag_r [RD_LAT];
  logic [CW-1:0]        infl_r;
  logic [CW-1:0]        cnt_r;
  logic [EW-1:0]        fifo_r [FIFO_DEPTH];
  logic [FAW-1:0]       wr_ptr_r;
  logic [FAW-1:0]       rd_ptr_r;

  logic                 issue_s;
  logic                 credit_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 last_s;
  logic [2:0]           tag_s;
  logic [CW-1:0]        used_s;
  logic [EW-1:0]        head_s;

  // Issue/credit decision, issue-time tags and FIFO-head output mux
  always_comb begin
    head_s    = fifo_r[rd_ptr_r];
    out_valid = (cnt_r != '0);
    pop_s     = out_valid && out_ready;
    push_s    = vld_r[RD_LAT-1];
    // An entry leaving this cycle frees its slot for a read issued in the same cycle.
    used_s    = infl_r + cnt_r - CW'(pop_s);
    credit_s  = (used_s < CW'(FIFO_DEPTH));
    issue_s   = 1'b0;
    case (state_r)
      S_IDLE:  issue_s = start && credit_s;
      S_ISSUE: issue_s = credit_s;
      default: issue_s = 1'b0;
    endcase
    last_s      = (addr_r == LAST_ADDR);
    tag_s[2]    = (x_r == '0) && (y_r == '0);
    tag_s[1]    = (x_r == LAST_X);
    tag_s[0]    = (x_r == LAST_X) && (y_r == LAST_Y);
    rd_en       = issue_s;
    rd_addr     = addr_r;
    out_pix     = out_valid ? head_s[EW-1:3] : '0;
    out_sof     = out_valid ? head_s[2] : 1'b0;
    out_eol     = out_valid ? head_s[1] : 1'b0;
    out_eof     = out_valid ? head_s[0] : 1'b0;
    busy        = (state_r != S_IDLE);
    done        = done_r;
    frame_count = frames_r;
  end

  // Frame FSM with raster counters, done pulse and frame counter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r  <= S_IDLE;
      x_r      <= '0;
      y_r      <= '0;
      addr_r   <= '0;
      done_r   <= 1'b0;
      frames_r <= 16'd0;
    end else begin
      done_r <= 1'b0;
      if (issue_s) begin
        if (last_s) begin
          x_r    <= '0;
          y_r    <= '0;
          addr_r <= '0;
        end else begin
          addr_r <= addr_r + ADDR_BITS'(1);
          if (x_r == LAST_X) begin
            x_r <= '0;
            y_r <= y_r + YW'(1);
          end else begin
            x_r <= x_r + XW'(1);
          end
        end
      end
      case (state_r)
        S_IDLE: begin
          if (issue_s) state_r <= last_s ? S_DRAIN : S_ISSUE;
        end
        S_ISSUE: begin
          if (issue_s && last_s) state_r <= S_DRAIN;
        end
        S_DRAIN: begin
          // The eof entry is the final one, so its acceptance means everything has drained.
          if (pop_s && head_s[0]) begin
            state_r  <= S_IDLE;
            done_r   <= 1'b1;
            frames_r <= frames_r + 16'd1;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Read-latency shadow pipe: valid bit and tags travel with each outstanding read
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      vld_r  <= '0;
      infl_r <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_r[i] <= 3'b000;
    end else begin
      vld_r[0] <= issue_s;
      tag_r[0] <= tag_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        tag_r[i] <= tag_r[i-1];
      end
      infl_r <= infl_r + CW'(issue_s) - CW'(push_s);
    end
  end

  // Skid FIFO storing {pixel, sof, eol, eof}
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_r[i] <= '0;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= {rd_data, tag_r[RD_LAT-1]};
        wr_ptr_r         <= wr_ptr_r + FAW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + FAW'(1);
      cnt_r <= cnt_r + CW'(push_s) - CW'(pop_s);
    end
  end

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Synthesizable frame read-out engine for the bottle-flip display path.
- Walks a PX_WIDTH x PX_HEIGHT pixel framebuffer in raster order through a fixed-latency read port.
- Emits pixels on a valid/ready stream tagged with start-of-frame, end-of-line and end-of-frame.
- Replaces the simulation-only frame dump loop; feeds a frame-capture/UART/debug sink; generalised in geometry, pixel width and memory latency, and supports backpressure.

Parameters:
- PX_WIDTH, 160, pixels per line (>=1)
- PX_HEIGHT, 120, lines per frame (>=1)
- PIX_BITS, 3, bits per pixel (colour code)
- ADDR_BITS, 16, framebuffer address width; PX_WIDTH*PX_HEIGHT <= 2^ADDR_BITS
- RD_LAT, 1, cycles from rd_en/rd_addr to valid rd_data (>=1)
- FIFO_DEPTH, 4, output skid FIFO entries (power of two, >=2); full throughput requires FIFO_DEPTH >= RD_LAT+1

Ports:
- clk  in  1  master clock
- clr  in  1  asynchronous active-high reset
- start  in  1  request one frame scan; sampled only when busy=0
- rd_en  out  1  framebuffer read strobe
- rd_addr  out  ADDR_BITS  framebuffer read address
- rd_data  in  PIX_BITS  read data, valid RD_LAT cycles after rd_en
- out_pix  out  PIX_BITS  streamed pixel
- out_valid  out  1  out_pix/tags valid
- out_ready  in  1  sink accepts when high with out_valid
- out_sof  out  1  tag: pixel (0,0)
- out_eol  out  1  tag: last pixel of a line
- out_eof  out  1  tag: last pixel of frame
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after last pixel accepted
- frame_count  out  16  completed frames, wraps 65535->0

Behaviour:
- Reset (async, clr=1): state IDLE; all outputs 0; x/y/address counters, in-flight pipe, FIFO pointers and frame_count cleared. Reset mid-frame aborts with no done pulse; in-flight reads are discarded.
- FSM:
  - IDLE: start=1 -> ISSUE; busy=1 the next cycle.
  - ISSUE: issue reads; after the final address (PX_WIDTH*PX_HEIGHT-1) is issued -> DRAIN.
  - DRAIN: when the FIFO and in-flight pipe are empty and the last pixel has been accepted -> IDLE; done=1 for one cycle and frame_count+1 in that same cycle; busy=0 from that cycle.
- start while busy=1: ignored. start in the done cycle: accepted, since busy=0.
- Address generation:
  - Incremental only; no multiplier. x counts 0..PX_WIDTH-1; on wrap, y increments; rd_addr increments by 1 per issued read starting at 0.
  - Tags are computed at issue time: sof = (x==0 && y==0), eol = (x==PX_WIDTH-1), eof = eol && (y==PX_HEIGHT-1).
  - PX_WIDTH=1: every pixel is eol.
- Credit flow control:
  - Issue a read only when in_flight + fifo_count < FIFO_DEPTH, so the FIFO never overflows regardless of out_ready.
  - in_flight = number of reads issued whose data has not yet returned.
  - Tags travel alongside in an RD_LAT-stage valid/tag shift register; rd_data is written to the FIFO when the stage-RD_LAT valid bit is set.
- Output:
  - out_valid = FIFO non-empty; out_pix and tags come from the FIFO head, first-word-fall-through.
  - Pop on out_valid && out_ready.
  - While out_ready=0, out_pix and tags hold stable.
  - Simultaneous push and pop in the same cycle is legal; the count is unchanged.
- Latency: first out_valid appears RD_LAT+1 cycles after the start cycle. Sustained 1 pixel/cycle with out_ready=1 and FIFO_DEPTH >= RD_LAT+1.
- rd_addr is held at its last value when rd_en=0. It is don't-care for the memory.

Test Plan:
- PX_WIDTH=4, PX_HEIGHT=3, RD_LAT=2, FIFO_DEPTH=4, memory[a]=a mod 8, out_ready=1, start pulse -> 12 pixels 0,1,..,7,0,1,2,3 on consecutive cycles; first out_valid 3 cycles after start; sof on pixel 0; eol on pixels 3,7,11; eof on pixel 11; done 1 cycle later; frame_count=1.
- Same config, out_ready toggling 1,0,0,1,... -> identical pixel/tag sequence; never more than 4 entries buffered; out_pix stable while stalled; rd_en gated.
- out_ready=0 for 20 cycles after start -> exactly 4 reads issued, then rd_en=0; release -> remaining 8 pixels delivered, no loss or duplication.
- clr pulsed at pixel 6 -> outputs 0 immediately; no done; frame_count=0; new start -> full frame from pixel 0 with sof.
- start held high continuously -> back-to-back frames; start re-accepted in each done cycle; frame_count=3 after 3 frames; start pulses during busy ignored.
- PX_WIDTH=1, PX_HEIGHT=1, RD_LAT=1 -> single pixel with sof=eol=eof=1, then done; frame_count wrap checked by preloading 65535 via 65535 frames in a fast sim -> 0.
